// File: rtl/mux2_arbiter.sv
// mux2_arbiter: two-requester round-robin arbiter with a one-entry output buffer.
// It chooses which valid/ready requester goes next and steers that requester
// through the shared mux2 datapath; the registered grant drives mux2.select.
// Optional feature: define MUX2_ARBITER_BURST_LOCK_EN to hold the grant on one
// requester until it delivers a beat with its last flag set. Without the macro,
// arbitration runs per beat and the last flags only pass through to out_last.
module mux2_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in0_data,
    input  logic         in0_valid,
    input  logic         in0_last,
    output logic         in0_ready,
    input  logic [N-1:0] in1_data,
    input  logic         in1_valid,
    input  logic         in1_last,
    output logic         in1_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic         select
);

    // EMPTY and FULL mirror the buffer occupancy; LOCKED means a burst owns
    // the grant (reachable only when burst lock is compiled in).
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic           r_outValid;
    logic [N-1:0]   r_outData;
    logic           r_outLast;
    logic           r_select;
    logic           r_lastServed;

    logic           w_space;
    logic           w_in0Ready;
    logic           w_in1Ready;
    logic           w_accept;
    logic [N-1:0]   w_muxData;
    logic           w_muxLast;
    logic           w_outValidNext;
    logic [N-1:0]   w_outDataNext;
    logic           w_outLastNext;
    logic           w_lastServedNext;
    logic           w_lockNext;
    logic           w_selectNext;

    // Handshake: the buffer has room when empty or draining this cycle, and
    // only the currently granted requester sees ready; reset blocks both.
    always_comb begin
        w_space    = !r_outValid || out_ready;
        w_in0Ready = w_space && (r_select == 1'b0) && !rst;
        w_in1Ready = w_space && (r_select == 1'b1) && !rst;
        w_accept   = (w_in0Ready && in0_valid) || (w_in1Ready && in1_valid);
    end

    // Shared mux2 datapath steered by the registered grant.
    always_comb begin
        w_muxData = r_select ? in1_data : in0_data;
        w_muxLast = r_select ? in1_last : in0_last;
    end

    // Output buffer next state: load on accept (even while draining), clear
    // valid on a drain with nothing new, otherwise hold everything stable.
    always_comb begin
        w_outValidNext   = r_outValid;
        w_outDataNext    = r_outData;
        w_outLastNext    = r_outLast;
        w_lastServedNext = r_lastServed;
        if (w_accept) begin
            w_outValidNext   = 1'b1;
            w_outDataNext    = w_muxData;
            w_outLastNext    = w_muxLast;
            w_lastServedNext = r_select;
        end else if (out_ready) begin
            w_outValidNext   = 1'b0;
        end
    end

    // Burst lock: an accepted beat without last keeps the grant, a beat with
    // last releases it. Without the feature the lock never engages.
    always_comb begin
        w_lockNext = (r_state == LOCKED);
`ifdef MUX2_ARBITER_BURST_LOCK_EN
        if (w_accept) begin
            w_lockNext = !w_muxLast;
        end
`else
        w_lockNext = 1'b0;
`endif
        if (w_lockNext) begin
            w_stateNext = LOCKED;
        end else if (w_outValidNext) begin
            w_stateNext = FULL;
        end else begin
            w_stateNext = EMPTY;
        end
    end

    // Next grant from current valids and the post-update service history, so
    // contention alternates every cycle; a held lock freezes the grant.
    always_comb begin
        w_selectNext = r_select;
        if (w_stateNext != LOCKED) begin
            if (in0_valid && !in1_valid) begin
                w_selectNext = 1'b0;
            end else if (in1_valid && !in0_valid) begin
                w_selectNext = 1'b1;
            end else if (in0_valid && in1_valid) begin
                w_selectNext = !w_lastServedNext;
            end
        end
    end

    // State register with synchronous reset; any buffered beat is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_outValid   <= 1'b0;
            r_outData    <= '0;
            r_outLast    <= 1'b0;
            r_select     <= 1'b0;
            r_lastServed <= 1'b1;
        end else begin
            r_state      <= w_stateNext;
            r_outValid   <= w_outValidNext;
            r_outData    <= w_outDataNext;
            r_outLast    <= w_outLastNext;
            r_select     <= w_selectNext;
            r_lastServed <= w_lastServedNext;
        end
    end

    assign in0_ready = w_in0Ready;
    assign in1_ready = w_in1Ready;
    assign out_data  = r_outData;
    assign out_valid = r_outValid;
    assign out_last  = r_outLast;
    assign select    = r_select;

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: directed scoreboard bench for mux2_arbiter.
// Expected beats are queued as each test is issued; a monitor pops and
// compares whenever the output buffer hands a beat to the consumer.
module tb_mux2_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] in0_data;
    logic         in0_valid;
    logic         in0_last;
    logic         in0_ready;
    logic [N-1:0] in1_data;
    logic         in1_valid;
    logic         in1_last;
    logic         in1_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic         select;

    int compared   = 0;
    int mismatched = 0;
    logic [N:0] expQ[$];

    mux2_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .select    (select)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [N-1:0] d0, input logic l0,
                                 input logic v1, input logic [N-1:0] d1, input logic l1,
                                 input logic oRdy);
        in0_valid = v0;
        in0_data  = d0;
        in0_last  = l0;
        in1_valid = v1;
        in1_data  = d1;
        in1_last  = l1;
        out_ready = oRdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [N-1:0] d, input logic l);
        expQ.push_back({l, d});
    endtask

    // Monitor: a beat leaves the buffer at the next edge when valid and ready
    // are both high; compare it against the oldest expected beat.
    always @(negedge clk) begin : monitor
        logic [N:0] e;
        if (!rst && out_valid && out_ready) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat", out_data, out_last);
            end else begin
                e = expQ.pop_front();
                if ({out_last, out_data} !== e) begin
                    mismatched++;
                    $display("[TB] FAIL out_beat: got data 0x%0h last %0b, expected data 0x%0h last %0b",
                             out_data, out_last, e[N-1:0], e[N]);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held two cycles with both requesters asking.
        rst = 1'b1;
        applyStimulus(1'b1, 8'hE0, 1'b1, 1'b1, 8'hE1, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in0_ready", 32'(in0_ready), 32'd0);
        checkOutput("reset_in1_ready", 32'(in1_ready), 32'd0);
        checkOutput("reset_select", 32'(select), 32'd0);

        // First beat after release comes from in0.
        pushExp(8'hE0, 1'b1);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("first_beat_data", 32'(out_data), 32'hE0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();

        // Single requester: in1 streams three beats back to back.
        pushExp(8'h11, 1'b1);
        pushExp(8'h22, 1'b1);
        pushExp(8'h33, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1);
        tick();
        checkOutput("single_select", 32'(select), 32'd1);
        checkOutput("single_in0_ready", 32'(in0_ready), 32'd0);
        in1_data = 8'h22;
        tick();
        in1_data = 8'h33;
        tick();
        checkOutput("single_last_data", 32'(out_data), 32'h33);
        checkOutput("single_last_valid", 32'(out_valid), 32'd1);
        in1_valid = 1'b0;
        tick();

        // Fresh reset, then continuous contention alternates A0,B0,A1,B1,...
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pushExp(8'(8'hA0 + i), 1'b1);
            pushExp(8'(8'hB0 + i), 1'b1);
        end
        for (int j = 0; j < 6; j++) begin
            applyStimulus(1'b1, 8'(8'hA0 + (j + 1) / 2), 1'b1, 1'b1, 8'(8'hB0 + j / 2), 1'b1, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkOutput("contention_drained", 32'(out_valid), 32'd0);

        // Backpressure: 0x5C held through a 3-cycle stall, consumed once.
        pushExp(8'h5C, 1'b1);
        pushExp(8'h77, 1'b1);
        applyStimulus(1'b1, 8'h5C, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("stall_data", 32'(out_data), 32'h5C);
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_in0_ready", 32'(in0_ready), 32'd0);
            checkOutput("stall_in1_ready", 32'(in1_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        in1_valid = 1'b0;
        tick();

`ifdef MUX2_ARBITER_BURST_LOCK_EN
        // Burst lock: three in0 beats go out before in1 gets the grant.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pushExp(8'hD0, 1'b0);
        pushExp(8'hD1, 1'b0);
        pushExp(8'hD2, 1'b1);
        pushExp(8'hC0, 1'b1);
        applyStimulus(1'b1, 8'hD0, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b1);
        tick();
        checkOutput("burst_in1_blocked", 32'(in1_ready), 32'd0);
        in0_data = 8'hD1;
        tick();
        checkOutput("burst_in1_blocked2", 32'(in1_ready), 32'd0);
        in0_data = 8'hD2;
        in0_last = 1'b1;
        tick();
        checkOutput("burst_release_select", 32'(select), 32'd1);
        checkOutput("burst_release_in1_ready", 32'(in1_ready), 32'd1);
        in0_valid = 1'b0;
        tick();
        in1_valid = 1'b0;
        tick();

        // Mid-burst reset discards the buffered beat and clears the lock.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 8'hE0, 1'b0, 1'b1, 8'hE1, 1'b1, 1'b0);
        tick();
        checkOutput("midburst_buffered", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("midburst_reset_valid", 32'(out_valid), 32'd0);
        checkOutput("midburst_reset_select", 32'(select), 32'd0);
        pushExp(8'hF0, 1'b1);
        pushExp(8'hF1, 1'b1);
        rst = 1'b0;
        applyStimulus(1'b1, 8'hF0, 1'b1, 1'b1, 8'hF1, 1'b1, 1'b1);
        tick();
        checkOutput("midburst_in0_wins", 32'(out_data), 32'hF0);
        in0_valid = 1'b0;
        tick();
        in1_valid = 1'b0;
        tick();
`endif

        // Let any outstanding beats drain, bounded.
        for (int k = 0; k < 20 && expQ.size() != 0; k++) begin
            tick();
        end
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
